serial_frame_tx: RTL and testbench

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_frame_pkg.sv | 23 ++
 rtl/frame_fifo.sv | 55 +++++
 rtl/serial_frame_tx.sv | 97 +++++++++
 tb/tb_serial_frame_tx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared constants and types for the serial frame transmitter.
package serial_frame_pkg;

  localparam int unsigned FRAME_BITS = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned SLOT_W     = $clog2(FRAME_BITS);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned COUNT_W    = $clog2(FIFO_DEPTH + 1);

  localparam logic [FRAME_BITS-1:0] IDLE_WORD   = 4'b0000;
  localparam logic [FRAME_BITS-1:0] MARKER_WORD = 4'b1001;

  typedef enum logic [1:0] {
    LdIdle,
    LdData,
    LdMarker
  } load_sel_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Small word FIFO feeding the frame loader; push is ignored when full, pop when empty.
module frame_fifo
  import serial_frame_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [FRAME_BITS-1:0] i_data,
  output logic [FRAME_BITS-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [COUNT_W-1:0]    o_count
);

  logic [FRAME_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [COUNT_W-1:0]    r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == COUNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= IDLE_WORD;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      if (w_push && !w_pop) begin
        r_count <= r_count + COUNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - COUNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Periodic 4-slot serial framer: IDLE, data or (with MARKER_EN defined) a marker
// frame ahead of each burst. Slot counter, loader and shifter live here.
module serial_frame_tx
  import serial_frame_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [FRAME_BITS-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out,
  output logic                  frame_start,
  output logic                  data_frame
);

`ifdef MARKER_EN
  localparam bit MarkerEn = 1'b1;
`else
  localparam bit MarkerEn = 1'b0;
`endif

  logic [SLOT_W-1:0]     r_slot;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_last_idle;
  logic                  r_data_frame;

  logic [FRAME_BITS-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [COUNT_W-1:0]    w_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_load;
  load_sel_e             w_sel;

  // Ready depends only on registered occupancy, never on the same-cycle pop.
  assign in_ready = (w_count < COUNT_W'(FIFO_DEPTH));
  assign w_push   = in_valid && !w_full;
  assign w_load   = (r_slot == SLOT_W'(FRAME_BITS - 1));
  assign w_pop    = w_load && (w_sel == LdData);

  always_comb begin
    w_sel = LdIdle;
    if (!w_empty) begin
      w_sel = (MarkerEn && r_last_idle) ? LdMarker : LdData;
    end
  end

  frame_fifo u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (in_data),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_slot       <= '0;
      r_shift      <= IDLE_WORD;
      r_last_idle  <= 1'b1;
      r_data_frame <= 1'b0;
    end else begin
      r_slot <= r_slot + SLOT_W'(1);
      if (w_load) begin
        unique case (w_sel)
          LdMarker: begin
            r_shift      <= MARKER_WORD;
            r_last_idle  <= 1'b0;
            r_data_frame <= 1'b0;
          end
          LdData: begin
            r_shift      <= w_head;
            r_last_idle  <= 1'b0;
            r_data_frame <= 1'b1;
          end
          default: begin
            r_shift      <= IDLE_WORD;
            r_last_idle  <= 1'b1;
            r_data_frame <= 1'b0;
          end
        endcase
      end else begin
        r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  assign out         = r_shift[FRAME_BITS-1];
  assign frame_start = (r_slot == '0);
  assign data_frame  = r_data_frame;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Table-driven bench for serial_frame_tx; expected bits are written out by hand per cycle.
module tb_serial_frame_tx;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out;
  logic       frame_start;
  logic       data_frame;

  serial_frame_tx dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out         (out),
    .frame_start (frame_start),
    .data_frame  (data_frame)
  );

  always #5 CLK = ~CLK;

  // exp = {out, frame_start, data_frame, in_ready}
  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef MARKER_EN
  localparam logic [3:0] E84 = 4'b1100;
  localparam logic [3:0] E85 = 4'b0000;
  localparam logic [3:0] E86 = 4'b0000;
`else
  localparam logic [3:0] E84 = 4'b1111;
  localparam logic [3:0] E85 = 4'b0010;
  localparam logic [3:0] E86 = 4'b1010;
`endif

  task automatic add(input logic v, input logic [3:0] d, input logic o, input logic df,
                     input logic r);
    vec_t e;
    e.v   = v;
    e.d   = d;
    e.exp = {o, ((tbl.size() % 4) == 0), df, r};
    tbl.push_back(e);
  endtask

  // One frame of no input; r[3] is in_ready for the frame's first cycle.
  task automatic frm(input logic [3:0] w, input logic df, input logic [3:0] r);
    for (int k = 3; k >= 0; k--) begin
      add(1'b0, 4'h0, w[k], df, r[k]);
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] exp);
    logic [3:0] got;
    got = {out, frame_start, data_frame, in_ready};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got {out,fs,df,rdy}=%b required %b", name, idx, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
`ifdef MARKER_EN
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    add(1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    frm(4'h6, 1'b1, 4'b1111);
    frm(4'h2, 1'b1, 4'b1111);
    frm(4'h0, 1'b0, 4'b1111);
`else
    repeat (4) frm(4'h0, 1'b0, 4'b1111);
    // Single word pushed at slot 1.
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    frm(4'hB, 1'b1, 4'b1111);
    frm(4'h0, 1'b0, 4'b1111);
    // Backpressure: third word refused.
    add(1'b1, 4'hA, 1'b0, 1'b0, 1'b1);
    add(1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
    add(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    frm(4'hA, 1'b1, 4'b1111);
    frm(4'h5, 1'b1, 4'b1111);
    frm(4'h0, 1'b0, 4'b1111);
    // Full FIFO with push offered on the load edge, then a next-cycle push.
    add(1'b1, 4'hC, 1'b0, 1'b0, 1'b1);
    add(1'b1, 4'h9, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'h3, 1'b1, 1'b1, 1'b1);
    add(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    frm(4'h9, 1'b1, 4'b1111);
    frm(4'h3, 1'b1, 4'b1111);
    // Push on the load edge into an empty FIFO waits a full frame.
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
    frm(4'h7, 1'b1, 4'b1111);
    frm(4'hE, 1'b1, 4'b1111);
    frm(4'h0, 1'b0, 4'b1111);
`endif

    // Reset held with in_valid high: nothing may be stored.
    RESET    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'hF;
    #1;
    chk("reset_hold", 0, 4'b0101);
    tick();
    chk("reset_hold", 1, 4'b0101);
    tick();
    chk("reset_hold", 2, 4'b0101);
    in_valid = 1'b0;
    RESET    = 1'b1;

    foreach (tbl[i]) begin
      chk("vec", i, tbl[i].exp);
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      tick();
    end

    // Reset asserted at slot 2 with words queued.
    chk("rst_pre", 0, 4'b0101);
    in_valid = 1'b1;
    in_data  = 4'hB;
    tick();
    chk("rst_pre", 1, 4'b0001);
    in_data = 4'hD;
    tick();
    chk("rst_pre", 2, 4'b0000);
    in_valid = 1'b0;
    tick();
    chk("rst_pre", 3, 4'b0000);
    tick();
    chk("rst_pre", 4, E84);
    in_valid = 1'b1;
    in_data  = 4'h6;
    tick();
    chk("rst_pre", 5, E85);
    in_valid = 1'b0;
    tick();
    chk("rst_pre", 6, E86);
    RESET = 1'b0;
    #1;
    chk("rst_async", 0, 4'b0101);
    tick();
    chk("rst_async", 1, 4'b0101);
    tick();
    chk("rst_async", 2, 4'b0101);
    RESET = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("post_rst", k, {1'b0, ((k % 4) == 0), 1'b0, 1'b1});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
